// File: rtl/kp_pkg.sv
// kp_pkg: shared types, sizes and key labels for the keypad scanner
package kp_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
    typedef enum logic [1:0] {EMPTY, SINGLE, MULTI} frame_class_t;
    localparam logic [7:0] KEY_LABEL [16] = '{
        "1", "2", "3", "A",
        "4", "5", "6", "B",
        "7", "8", "9", "C",
        "0", "F", "E", "D"
    };
    function automatic logic [7:0] key_label(input logic [3:0] k);
        return KEY_LABEL[k];
    endfunction
endpackage

// File: rtl/kp_col_scanner.sv
// kp_col_scanner: dwell divider and active-low one-hot column drive
module kp_col_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    output logic [1:0]          col_idx,
    output logic [NUM_COLS-1:0] col,
    output logic                sample_strobe
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
    logic [CW-1:0] dwell;
    assign sample_strobe = dwell == LAST;
    // step to the next column at the end of each dwell, keeping col aligned with col_idx
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell   <= '0;
            col_idx <= '0;
            col     <= 4'b1110;
        end else if (sample_strobe) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
            col     <= ~(4'b0001 << (col_idx + 2'd1));
        end else begin
            dwell <= dwell + 1'b1;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad reader with frame debounce and press events
module keypad_scanner
    import kp_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_down
);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DB_ONE = DW'(1);
    logic [NUM_ROWS-1:0] row_meta, row_sync;
    logic [1:0]          col_idx;
    logic                sample_strobe, frame_end;
    logic [15:0]         snap, snap_next;
    logic [4:0]          ones;
    logic [3:0]          single_k, cand;
    logic [DW-1:0]       db_cnt, db_inc;
    frame_class_t        cls;
    state_t              state;

    kp_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk          (clk),
        .rst          (rst),
        .col_idx      (col_idx),
        .col          (col),
        .sample_strobe(sample_strobe)
    );

    assign frame_end = sample_strobe && col_idx == 2'd3;
    assign db_inc    = db_cnt + 1'b1;

    // bring the asynchronous row lines into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // merge the current column into the frame and classify it by number of pressed keys
    always_comb begin
        snap_next = snap;
        snap_next[col_idx*4 +: 4] = ~row_sync;
        ones     = '0;
        single_k = '0;
        for (int b = 0; b < NUM_ROWS * NUM_COLS; b++) begin
            if (snap_next[b]) begin
                ones     = ones + 5'd1;
                single_k = {b[1:0], b[3:2]};
            end
        end
        cls = ones == 5'd0 ? EMPTY : ones == 5'd1 ? SINGLE : MULTI;
    end

    // store each column's pressed rows on its last dwell cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) snap <= '0;
        else if (sample_strobe) snap <= snap_next;
    end

    // press/release debounce, advanced once per completed frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cand      <= '0;
            db_cnt    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_end) begin
                case (state)
                    IDLE: if (cls == SINGLE) begin
                        cand   <= single_k;
                        db_cnt <= DB_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_code  <= single_k;
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            state     <= HELD;
                        end else begin
                            state <= PRESS_DB;
                        end
                    end
                    PRESS_DB: if (cls == SINGLE && single_k == cand) begin
                        db_cnt <= db_inc;
                        if (db_inc == DB_MAX) begin
                            key_code  <= cand;
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            state     <= HELD;
                        end
                    end else if (cls == SINGLE) begin
                        cand   <= single_k;
                        db_cnt <= DB_ONE;
                    end else begin
                        db_cnt <= '0;
                        state  <= IDLE;
                    end
                    HELD: if (cls == EMPTY) begin
                        db_cnt <= DB_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            key_down <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= RELEASE_DB;
                        end
                    end
                    RELEASE_DB: if (cls == EMPTY) begin
                        db_cnt <= db_inc;
                        if (db_inc == DB_MAX) begin
                            key_down <= 1'b0;
                            db_cnt   <= '0;
                            state    <= IDLE;
                        end
                    end else begin
                        state <= HELD;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce and event reporting
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row, col, key_code;
    logic        key_valid, key_down;
    logic [15:0] pressed = '0;
    logic [3:0]  last_code = '0;
    int          checks = 0, failures = 0, pulses = 0, base = 0;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .row      (row),
        .col      (col),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_down (key_down)
    );

    always #5 clk = ~clk;

    // ideal switch matrix: a row reads low when a pressed key sits on a driven column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    // count every cycle key_valid is high, so a stretched pulse shows up as extra events
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulses++;
            last_code = key_code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int b, input int max, input string tag);
        int n = 0;
        while (pulses == b && n < max) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        chk(tag, pulses - b, 1);
    endtask

    task automatic wait_release(input int max, input string tag);
        int n = 0;
        while (key_down !== 1'b0 && n < max) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk(tag, key_down, 0);
    endtask

    task automatic align_col2();
        int n = 0;
        while (col === 4'b1011 && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (col !== 4'b1011 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("align_col2", col, 4'b1011);
    endtask

    initial begin
        logic [3:0] ec;
        idle(3);
        chk("rst_col", col, 4'b1110);
        chk("rst_valid", key_valid, 0);
        chk("rst_down", key_down, 0);
        chk("rst_code", key_code, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ec = ~(4'b0001 << ((i / 4) % 4));
            chk("t1_col", col, ec);
            @(negedge clk);
        end
        idle(48);
        chk("t1_pulses", pulses, 0);
        chk("t1_down", key_down, 0);
        chk("t1_code", key_code, 0);

        pressed[6] = 1'b1;
        wait_pulse(0, 53, "t2_pulse");
        chk("t2_code", last_code, 6);
        chk("t2_down", key_down, 1);
        idle(64);
        chk("t2_single", pulses, 1);
        chk("t2_held", key_down, 1);
        pressed[6] = 1'b0;
        idle(8);
        chk("t2_down_lag", key_down, 1);
        wait_release(64, "t2_release");
        chk("t2_code_kept", key_code, 6);
        chk("t2_no_extra", pulses, 1);

        align_col2();
        base = pulses;
        for (int i = 0; i < 8; i++) begin
            pressed[6] = ~pressed[6];
            idle(5);
        end
        chk("t3_bounce", pulses, base);
        pressed[6] = 1'b1;
        wait_pulse(base, 53, "t3_pulse");
        chk("t3_code", last_code, 6);
        idle(64);
        chk("t3_single", pulses, base + 1);
        pressed[6] = 1'b0;
        wait_release(64, "t3_release");

        base = pulses;
        pressed[0] = 1'b1;
        pressed[5] = 1'b1;
        idle(64);
        chk("t4_multi", pulses, base);
        chk("t4_multi_down", key_down, 0);
        pressed[5] = 1'b0;
        wait_pulse(base, 53, "t4_pulse");
        chk("t4_code", last_code, 0);
        pressed[0] = 1'b0;
        wait_release(64, "t4_release");

        base = pulses;
        pressed[6] = 1'b1;
        wait_pulse(base, 53, "t5_pulse6");
        chk("t5_code6", last_code, 6);
        pressed[9] = 1'b1;
        idle(32);
        chk("t5_both", pulses, base + 1);
        pressed[6] = 1'b0;
        idle(64);
        chk("t5_only9", pulses, base + 1);
        chk("t5_down", key_down, 1);
        chk("t5_code_hold", key_code, 6);
        pressed[9] = 1'b0;
        wait_release(64, "t5_release");
        chk("t5_no_extra", pulses, base + 1);
        pressed[9] = 1'b1;
        wait_pulse(base + 1, 53, "t5_pulse9");
        chk("t5_code9", last_code, 9);
        pressed[9] = 1'b0;
        wait_release(64, "t5_release9");

        align_col2();
        base = pulses;
        pressed[6] = 1'b1;
        idle(12);
        rst = 1'b1;
        #1;
        chk("t6a_col", col, 4'b1110);
        chk("t6a_code", key_code, 0);
        chk("t6a_down", key_down, 0);
        chk("t6a_valid", key_valid, 0);
        chk("t6a_none", pulses, base);
        idle(2);
        rst = 1'b0;
        wait_pulse(base, 53, "t6a_pulse");
        chk("t6a_recode", last_code, 6);
        chk("t6a_held", key_down, 1);
        idle(8);
        rst = 1'b1;
        #1;
        chk("t6b_col", col, 4'b1110);
        chk("t6b_code", key_code, 0);
        chk("t6b_down", key_down, 0);
        idle(2);
        rst = 1'b0;
        wait_pulse(base + 1, 53, "t6b_pulse");
        chk("t6b_recode", last_code, 6);
        idle(64);
        chk("t6b_once", pulses, base + 2);
        pressed = '0;
        wait_release(64, "t6b_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
